md_unit: RTL

MD_UNIT -- requirements
Module: md_unit

---
 rtl/md_if.sv | 27 ++
 rtl/md_unit.sv | 135 +++++++++++++
 2 files changed

// File: rtl/md_if.sv
`default_nettype none
// ============================================================================
// Module : md_if
// Brief  : EX-stage request / HI-LO result bundle for the multiply-divide unit.
// Rev    : 1.0  initial release
// ============================================================================
interface md_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, stall, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, stall, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// Module : md_unit
// Brief  : MIPS-style HI/LO multiply-divide unit with fixed-latency busy window.
// Rev    : 1.0  initial release
// ============================================================================
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  wire logic clk,
    input  wire logic reset,
    md_if.slave       bus
);

    localparam int c_MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W   = $clog2(c_MAX_CYC + 1);
    localparam logic [c_CNT_W-1:0] c_MULT_LD = c_CNT_W'(MULT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_DIV_LD  = c_CNT_W'(DIV_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    localparam logic [2:0] c_OP_MTHI = 3'd4;
    localparam logic [2:0] c_OP_MTLO = 3'd5;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    logic                 r_busy;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [31:0]          r_hi;
    logic [31:0]          r_lo;
    logic [31:0]          r_res_hi;
    logic [31:0]          r_res_lo;
    logic                 r_res_valid;

    logic                 w_is_md;
    logic                 w_signed;
    logic                 w_is_div;
    logic [63:0]          w_prod;
    logic                 w_neg_a;
    logic                 w_neg_b;
    logic [31:0]          w_mag_a;
    logic [31:0]          w_mag_b;
    logic [31:0]          w_quo;
    logic [31:0]          w_rem;
    logic [31:0]          w_res_hi;
    logic [31:0]          w_res_lo;
    logic                 w_res_valid;

    // op 0..3 are the multi-cycle ops; op[0] selects unsigned, op[1] selects divide
    assign w_is_md  = bus.start & ~bus.op[2];
    assign w_signed = ~bus.op[0];
    assign w_is_div = bus.op[1];

    assign bus.busy  = r_busy;
    assign bus.stall = r_busy | w_is_md;
    assign bus.hi    = r_hi;
    assign bus.lo    = r_lo;

    always_comb begin
        w_prod      = {{32{w_signed & bus.a[31]}}, bus.a} * {{32{w_signed & bus.b[31]}}, bus.b};
        w_neg_a     = w_signed & bus.a[31];
        w_neg_b     = w_signed & bus.b[31];
        w_mag_a     = w_neg_a ? (~bus.a + 32'd1) : bus.a;
        w_mag_b     = w_neg_b ? (~bus.b + 32'd1) : bus.b;
        w_quo       = 32'd0;
        w_rem       = 32'd0;
        w_res_hi    = w_prod[63:32];
        w_res_lo    = w_prod[31:0];
        w_res_valid = 1'b1;
        if (w_is_div) begin
            // Magnitude divide avoids the -2^31 / -1 overflow case entirely
            if (w_mag_b != 32'd0) begin
                w_quo = w_mag_a / w_mag_b;
                w_rem = w_mag_a % w_mag_b;
            end
            w_res_lo    = (w_neg_a ^ w_neg_b) ? (~w_quo + 32'd1) : w_quo;
            w_res_hi    = w_neg_a ? (~w_rem + 32'd1) : w_rem;
            w_res_valid = (bus.b != 32'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_cnt       <= '0;
            r_hi        <= 32'd0;
            r_lo        <= 32'd0;
            r_res_hi    <= 32'd0;
            r_res_lo    <= 32'd0;
            r_res_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_is_md) begin
                        r_res_hi    <= w_res_hi;
                        r_res_lo    <= w_res_lo;
                        r_res_valid <= w_res_valid;
                        r_cnt       <= w_is_div ? c_DIV_LD : c_MULT_LD;
                        r_state     <= S_RUN;
                        r_busy      <= 1'b1;
                    end else if (bus.start && bus.op == c_OP_MTHI) begin
                        r_hi <= bus.a;
                    end else if (bus.start && bus.op == c_OP_MTLO) begin
                        r_lo <= bus.a;
                    end
                end
                S_RUN: begin
                    // Write-back coincides with busy falling
                    if (r_cnt <= c_CNT_ONE) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                        if (r_res_valid) begin
                            r_hi <= r_res_hi;
                            r_lo <= r_res_lo;
                        end
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
